// File: rtl/mem_stage_if.sv
// mem_stage_if
// Request/response bus between the memory stage and the external data RAM.
//
// Signals
//   dmemReq     request valid, held until dmemReady is seen
//   dmemWe      1 = store, 0 = load
//   dmemAddr    word-aligned byte address (bits [1:0] always 00)
//   dmemWdata   store data, already replicated into the addressed lanes
//   dmemByteEn  per-lane write/read enables, little-endian
//   dmemRdata   load data returned by the RAM (full word)
//   dmemReady   RAM has completed the current request
//
// Modports
//   master  the memory stage (drives the request, receives the response)
//   slave   the data RAM (receives the request, drives the response)
interface mem_stage_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemByteEn;
  logic [31:0] dmemRdata;
  logic        dmemReady;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn,
    input  dmemRdata, dmemReady
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn,
    output dmemRdata, dmemReady
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
// Data-memory access stage between EX/MEM and memWb. Issues loads and stores
// to a variable-latency data RAM, stalls the front of the pipeline while an
// access is outstanding, and aligns/extends load data. Every output toward
// memWb is registered; only stall is combinational.
//
// Optional feature macro: MEM_SUBWORD_EN
//   defined   : byte and half accesses with lane steering, store replication
//               and sign/zero extension of loads.
//   undefined : every access is a full word, byte enables are 1111, data is
//               passed through unshifted and only addr[1:0]!=00 faults.
//
// Ports
//   clock, reset        pipeline clock, synchronous active-high reset
//   exValid             EX/MEM slot holds a real instruction
//   memRead, memWrite   load / store (both high = store)
//   memSize             00 byte, 01 half, 1x word
//   memUnsigned         zero-extend loads
//   aluResultInput      effective address or ALU result
//   writeDataInput      store data
//   writeRegisterInput  destination register
//   wbControlInput      {regWrite, memToReg}
//   dmem                data RAM bus (master side)
//   stall               hold PC, IF/ID, ID/EX and EX/MEM
//   outValid            one-cycle result pulse toward memWb
//   readDataMemory      aligned and extended load data
//   aluResult           ALU result / access address / faulting address
//   writeRegister       destination register toward memWb
//   wbControl           write-back control, forced to 00 on bubbles/faults
//   misaligned          one-cycle misaligned-access fault pulse
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        exValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] aluResultInput,
  input  logic [31:0] writeDataInput,
  input  logic [4:0]  writeRegisterInput,
  input  logic [1:0]  wbControlInput,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        outValid,
  output logic [31:0] readDataMemory,
  output logic [31:0] aluResult,
  output logic [4:0]  writeRegister,
  output logic [1:0]  wbControl,
  output logic        misaligned
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Decoded view of the instruction currently offered by EX/MEM
  logic        mem_op;
  logic        mis_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // Handshakes between the FSM and the datapath registers
  logic accept;
  logic finish;

  // Request bus registers
  logic        req_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  // Latched operation, kept for the whole access
  logic [31:0] addr_q;
  logic        store_q;
  logic [4:0]  wreg_q;
  logic [1:0]  wbctl_q;
`ifdef MEM_SUBWORD_EN
  logic [1:0]  size_q;
  logic        uns_q;
`endif

  logic [31:0] load_data;

  assign mem_op = memRead | memWrite;

  // Alignment check, lane enables and store-data replication for the offered
  // instruction. Word is the fallback for every size so memSize=11 behaves
  // exactly like 10.
  always_comb begin
    mis_in   = (aluResultInput[1:0] != 2'b00);
    be_in    = 4'b1111;
    wdata_in = writeDataInput;
`ifdef MEM_SUBWORD_EN
    case (memSize)
      2'b00: begin
        mis_in   = 1'b0;
        be_in    = 4'b0001 << aluResultInput[1:0];
        wdata_in = {4{writeDataInput[7:0]}};
      end
      2'b01: begin
        mis_in   = aluResultInput[0];
        be_in    = aluResultInput[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{writeDataInput[15:0]}};
      end
      default: begin
        mis_in   = (aluResultInput[1:0] != 2'b00);
      end
    endcase
`endif
  end

`ifndef MEM_SUBWORD_EN
  // Size and signedness have no effect in the word-only build.
  logic unused_cfg;
  assign unused_cfg = ^{memSize, memUnsigned};
`endif

  // Load lane selection and extension, based on the latched access.
`ifdef MEM_SUBWORD_EN
  logic [31:0] rdata_shifted;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    rdata_shifted = dmem.dmemRdata >> {addr_q[1:0], 3'b000};
    lane8         = rdata_shifted[7:0];
    lane16        = addr_q[1] ? dmem.dmemRdata[31:16] : dmem.dmemRdata[15:0];
    load_data     = dmem.dmemRdata;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, lane8}  : {{24{lane8[7]}}, lane8};
      2'b01:   load_data = uns_q ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
      default: load_data = dmem.dmemRdata;
    endcase
  end
`else
  always_comb begin
    load_data = dmem.dmemRdata;
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. stall covers the accept cycle plus every ACCESS cycle
  // in which the RAM has not yet answered; in the ready cycle it drops so
  // EX/MEM can advance and present the next instruction right after.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (exValid && mem_op && !mis_in) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem.dmemReady) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          stall      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request bus and memWb output registers. outValid and misaligned default
  // low every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      be_q           <= '0;
      addr_q         <= '0;
      store_q        <= 1'b0;
      wreg_q         <= '0;
      wbctl_q        <= '0;
`ifdef MEM_SUBWORD_EN
      size_q         <= '0;
      uns_q          <= 1'b0;
`endif
      outValid       <= 1'b0;
      misaligned     <= 1'b0;
      readDataMemory <= '0;
      aluResult      <= '0;
      writeRegister  <= '0;
      wbControl      <= '0;
    end else begin
      outValid   <= 1'b0;
      misaligned <= 1'b0;
      if (accept) begin
        req_q     <= 1'b1;
        we_q      <= memWrite;
        wdata_q   <= wdata_in;
        be_q      <= be_in;
        addr_q    <= aluResultInput;
        store_q   <= memWrite;
        wreg_q    <= writeRegisterInput;
        wbctl_q   <= wbControlInput;
`ifdef MEM_SUBWORD_EN
        size_q    <= memSize;
        uns_q     <= memUnsigned;
`endif
        // Nothing may be written back while the access is in flight.
        wbControl <= 2'b00;
      end else if (finish) begin
        req_q         <= 1'b0;
        we_q          <= 1'b0;
        outValid      <= 1'b1;
        aluResult     <= addr_q;
        writeRegister <= wreg_q;
        wbControl     <= wbctl_q;
        if (!store_q) begin
          readDataMemory <= load_data;
        end
      end else if (state == IDLE) begin
        if (!exValid) begin
          wbControl <= 2'b00;
        end else if (mem_op) begin
          // Only a misaligned memory op reaches here: report the fault and
          // suppress write-back.
          misaligned    <= 1'b1;
          outValid      <= 1'b1;
          wbControl     <= 2'b00;
          aluResult     <= aluResultInput;
          writeRegister <= writeRegisterInput;
        end else begin
          outValid      <= 1'b1;
          aluResult     <= aluResultInput;
          writeRegister <= writeRegisterInput;
          wbControl     <= wbControlInput;
        end
      end
    end
  end

  assign dmem.dmemReq    = req_q;
  assign dmem.dmemWe     = we_q;
  assign dmem.dmemAddr   = {addr_q[31:2], 2'b00};
  assign dmem.dmemWdata  = wdata_q;
  assign dmem.dmemByteEn = be_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Randomised, self-checking bench for mem_stage. The bench plays the data RAM
// (chosen latency and read data per access) and predicts every result from a
// transaction-level model of the stage's rules. Build-time MEM_SUBWORD_EN is
// honoured by the model as well.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        exValid;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic [31:0] aluResultInput;
  logic [31:0] writeDataInput;
  logic [4:0]  writeRegisterInput;
  logic [1:0]  wbControlInput;
  logic        stall;
  logic        outValid;
  logic [31:0] readDataMemory;
  logic [31:0] aluResult;
  logic [4:0]  writeRegister;
  logic [1:0]  wbControl;
  logic        misaligned;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clock              (clock),
    .reset              (reset),
    .exValid            (exValid),
    .memRead            (memRead),
    .memWrite           (memWrite),
    .memSize            (memSize),
    .memUnsigned        (memUnsigned),
    .aluResultInput     (aluResultInput),
    .writeDataInput     (writeDataInput),
    .writeRegisterInput (writeRegisterInput),
    .wbControlInput     (wbControlInput),
    .dmem               (dmem_bus),
    .stall              (stall),
    .outValid           (outValid),
    .readDataMemory     (readDataMemory),
    .aluResult          (aluResult),
    .writeRegister      (writeRegister),
    .wbControl          (wbControl),
    .misaligned         (misaligned)
  );

  always #5 clock = ~clock;

  int check_count = 0;
  int fail_count  = 0;

  // Model of the values memWb should currently be holding
  logic [31:0] exp_rdm = '0;
  logic [31:0] exp_alu = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit model_aligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_SUBWORD_EN
    if (size == 2'd0) return 1'b1;
    if (size == 2'd1) return (addr % 2) == 0;
`endif
    return (addr % 4) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_SUBWORD_EN
    if (size == 2'd0) return 4'(1 << (addr % 4));
    if (size == 2'd1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
`endif
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
`ifdef MEM_SUBWORD_EN
    if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
`endif
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] val;
`ifdef MEM_SUBWORD_EN
    if (size == 2'd0) begin
      val = (rdata >> (8 * (addr % 4))) % 256;
      if (!uns && val >= 128) val = val + 32'hFFFF_FF00;
      return val;
    end
    if (size == 2'd1) begin
      val = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
      if (!uns && val >= 32768) val = val + 32'hFFFF_0000;
      return val;
    end
`endif
    return rdata;
  endfunction

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] wreg, input logic [1:0] wbc);
    exValid            = v;
    memRead            = rd;
    memWrite           = wr;
    memSize            = size;
    memUnsigned        = uns;
    aluResultInput     = addr;
    writeDataInput     = wd;
    writeRegisterInput = wreg;
    wbControlInput     = wbc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction, service it as the RAM would and check the result.
  task automatic runInstr(input logic v, input logic rd, input logic wr,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wreg, input logic [1:0] wbc,
                          input int latency, input logic [31:0] rdata);
    bit is_mem;
    is_mem = rd | wr;
    applyStimulus(v, rd, wr, size, uns, addr, wd, wreg, wbc);
    if (v && is_mem && model_aligned(size, addr)) begin
      #1;
      checkOutput("stall_accept", 32'(stall), 32'd1);
      tick();
      // EX/MEM garbage while the access is in flight must be ignored
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                    $urandom, $urandom, 5'($urandom), 2'($urandom));
      checkOutput("req_issue", 32'(dmem_bus.dmemReq), 32'd1);
      checkOutput("req_we", 32'(dmem_bus.dmemWe), 32'(wr));
      checkOutput("req_addr", dmem_bus.dmemAddr, addr - (addr % 4));
      checkOutput("req_be", 32'(dmem_bus.dmemByteEn), 32'(model_be(size, addr)));
      if (wr) checkOutput("req_wdata", dmem_bus.dmemWdata, model_wdata(size, wd));
      checkOutput("valid_in_access", 32'(outValid), 32'd0);
      for (int i = 0; i < latency; i++) begin
        dmem_bus.dmemReady = 1'b0;
        dmem_bus.dmemRdata = $urandom;
        #1;
        checkOutput("stall_wait", 32'(stall), 32'd1);
        tick();
        checkOutput("req_hold", 32'(dmem_bus.dmemReq), 32'd1);
        checkOutput("addr_hold", dmem_bus.dmemAddr, addr - (addr % 4));
        checkOutput("valid_wait", 32'(outValid), 32'd0);
      end
      dmem_bus.dmemReady = 1'b1;
      dmem_bus.dmemRdata = rdata;
      #1;
      checkOutput("stall_ready", 32'(stall), 32'd0);
      tick();
      dmem_bus.dmemReady = 1'b0;
      dmem_bus.dmemRdata = $urandom;
      if (!wr) exp_rdm = model_load(size, uns, addr, rdata);
      exp_alu = addr;
      checkOutput("done_valid", 32'(outValid), 32'd1);
      checkOutput("done_misaligned", 32'(misaligned), 32'd0);
      checkOutput("done_req_drop", 32'(dmem_bus.dmemReq), 32'd0);
      checkOutput("done_rdata", readDataMemory, exp_rdm);
      checkOutput("done_alu", aluResult, exp_alu);
      checkOutput("done_wreg", 32'(writeRegister), 32'(wreg));
      checkOutput("done_wbc", 32'(wbControl), 32'(wbc));
    end else begin
      // dmemReady must have no effect while idle
      dmem_bus.dmemReady = 1'($urandom);
      #1;
      checkOutput("stall_none", 32'(stall), 32'd0);
      tick();
      dmem_bus.dmemReady = 1'b0;
      checkOutput("no_req", 32'(dmem_bus.dmemReq), 32'd0);
      checkOutput("rdata_hold", readDataMemory, exp_rdm);
      if (!v) begin
        checkOutput("bubble_valid", 32'(outValid), 32'd0);
        checkOutput("bubble_wbc", 32'(wbControl), 32'd0);
        checkOutput("bubble_misaligned", 32'(misaligned), 32'd0);
        checkOutput("bubble_alu_hold", aluResult, exp_alu);
      end else if (is_mem) begin
        exp_alu = addr;
        checkOutput("fault_valid", 32'(outValid), 32'd1);
        checkOutput("fault_flag", 32'(misaligned), 32'd1);
        checkOutput("fault_wbc", 32'(wbControl), 32'd0);
        checkOutput("fault_addr", aluResult, exp_alu);
      end else begin
        exp_alu = addr;
        checkOutput("alu_valid", 32'(outValid), 32'd1);
        checkOutput("alu_misaligned", 32'(misaligned), 32'd0);
        checkOutput("alu_result", aluResult, exp_alu);
        checkOutput("alu_wreg", 32'(writeRegister), 32'(wreg));
        checkOutput("alu_wbc", 32'(wbControl), 32'(wbc));
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_rdata"}, readDataMemory, 32'd0);
    checkOutput({tag, "_alu"}, aluResult, 32'd0);
    checkOutput({tag, "_wreg"}, 32'(writeRegister), 32'd0);
    checkOutput({tag, "_wbc"}, 32'(wbControl), 32'd0);
    checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    checkOutput({tag, "_req"}, 32'(dmem_bus.dmemReq), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    int          kind;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
    dmem_bus.dmemReady = 1'b0;
    dmem_bus.dmemRdata = '0;
    tick();
    tick();
    reset = 1'b0;
    checkResetState("reset");

    $display("[TB] directed cases");
    runInstr(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd3, 2'b11, 3, 32'hDEADBEEF);
    runInstr(1, 1, 0, 2'b00, 0, 32'h13, 32'h0, 5'd4, 2'b11, 1, 32'h80112233);
    runInstr(1, 1, 0, 2'b00, 1, 32'h13, 32'h0, 5'd5, 2'b11, 0, 32'h80112233);
    runInstr(1, 0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 5'd0, 2'b00, 2, 32'h0);
    runInstr(1, 1, 0, 2'b10, 0, 32'h06, 32'h0, 5'd6, 2'b11, 0, 32'h0);
    runInstr(1, 0, 0, 2'b00, 0, 32'h1234, 32'h0, 5'd7, 2'b10, 0, 32'h0);
    runInstr(1, 0, 0, 2'b00, 0, 32'h5678, 32'h0, 5'd8, 2'b10, 0, 32'h0);
    runInstr(1, 0, 0, 2'b00, 0, 32'h9ABC, 32'h0, 5'd9, 2'b10, 0, 32'h0);
    runInstr(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 2'b10, 0, 32'h0);
    runInstr(1, 1, 1, 2'b11, 0, 32'h40, 32'h11223344, 5'd2, 2'b01, 1, 32'h0);

    $display("[TB] reset during access");
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 5'd10, 2'b11);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
    checkOutput("rst_pre_req", 32'(dmem_bus.dmemReq), 32'd1);
    reset = 1'b1;
    dmem_bus.dmemReady = 1'b0;
    tick();
    reset = 1'b0;
    checkResetState("rst_access");
    exp_rdm = '0;
    exp_alu = '0;
    runInstr(1, 1, 0, 2'b10, 0, 32'h44, 32'h0, 5'd11, 2'b11, 2, 32'hCAFEF00D);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      rd   = 1'b0;
      wr   = 1'b0;
      if (kind >= 6) begin
        rd = 1'b1;
      end else if (kind >= 3) begin
        wr = 1'b1;
        rd = 1'($urandom);
      end
      size = 2'($urandom);
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 2) == 0) addr = addr + 32'($urandom_range(0, 3));
      runInstr((kind != 0), rd, wr, size, 1'($urandom), addr, $urandom,
               5'($urandom), 2'($urandom), int'($urandom_range(0, 4)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
